// File: rtl/shift_in.sv
// Serial-to-parallel receiver: synchronizes an external shift clock, data and latch
// into ICE_CLK, assembles MSB-first frames and reports complete, short and long frames.
module shift_in #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  ICE_CLK,
  input  logic                  RST_N,
  input  logic                  SHIFT_CLOCK,
  input  logic                  SHIFT_DATA,
  input  logic                  SHIFT_LATCH,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  frame_error,
  output logic                  overrun,
  output logic                  busy
);

  localparam int CNT_W   = $clog2(DATA_WIDTH + 2);
  localparam int START_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2,
    OVER  = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] clk_sync_r;
  logic [SYNC_STAGES-1:0] data_sync_r;
  logic [SYNC_STAGES-1:0] latch_sync_r;
  logic                   clk_prev_r;
  logic                   latch_prev_r;
  logic [START_W-1:0]     start_cnt_r;

  state_t                 state_r;
  logic [CNT_W-1:0]       count_r;
  logic [DATA_WIDTH-1:0]  shreg_r;

  logic                   edge_en_s;
  logic                   clk_rise_s;
  logic                   latch_rise_s;
  logic                   data_bit_s;

  state_t                 state_nxt_s;
  logic [CNT_W-1:0]       count_nxt_s;
  logic [DATA_WIDTH-1:0]  shreg_nxt_s;
  logic [DATA_WIDTH-1:0]  dout_nxt_s;
  logic                   valid_nxt_s;
  logic                   err_nxt_s;
  logic                   ovr_nxt_s;

  // Input synchronizers plus previous-value registers for edge detection
  always_ff @(posedge ICE_CLK or negedge RST_N) begin
    if (!RST_N) begin
      clk_sync_r   <= '0;
      data_sync_r  <= '0;
      latch_sync_r <= '0;
      clk_prev_r   <= 1'b0;
      latch_prev_r <= 1'b0;
    end else begin
      clk_sync_r   <= {clk_sync_r[SYNC_STAGES-2:0], SHIFT_CLOCK};
      data_sync_r  <= {data_sync_r[SYNC_STAGES-2:0], SHIFT_DATA};
      latch_sync_r <= {latch_sync_r[SYNC_STAGES-2:0], SHIFT_LATCH};
      clk_prev_r   <= clk_sync_r[SYNC_STAGES-1];
      latch_prev_r <= latch_sync_r[SYNC_STAGES-1];
    end
  end

  // Startup window: edges are ignored until the synchronizers and previous-value
  // registers have both filled, so inputs idling high at release look level
  always_ff @(posedge ICE_CLK or negedge RST_N) begin
    if (!RST_N) begin
      start_cnt_r <= '0;
    end else if (start_cnt_r != START_W'(SYNC_STAGES + 1)) begin
      start_cnt_r <= start_cnt_r + 3'd1;
    end else begin
      start_cnt_r <= start_cnt_r;
    end
  end

  assign edge_en_s    = (start_cnt_r == START_W'(SYNC_STAGES + 1));
  assign clk_rise_s   = edge_en_s & clk_sync_r[SYNC_STAGES-1] & ~clk_prev_r;
  assign latch_rise_s = edge_en_s & latch_sync_r[SYNC_STAGES-1] & ~latch_prev_r;
  assign data_bit_s   = data_sync_r[SYNC_STAGES-1];

  // Next-state logic: a coincident clock edge is applied first, then the latch
  // is judged on the updated state
  always_comb begin
    state_nxt_s = state_r;
    count_nxt_s = count_r;
    shreg_nxt_s = shreg_r;
    dout_nxt_s  = data_out;
    valid_nxt_s = 1'b0;
    err_nxt_s   = 1'b0;
    ovr_nxt_s   = 1'b0;

    if (clk_rise_s) begin
      shreg_nxt_s = {shreg_r[DATA_WIDTH-2:0], data_bit_s};
      if (count_r != CNT_W'(DATA_WIDTH + 1)) begin
        count_nxt_s = count_r + CNT_W'(1);
      end else begin
        count_nxt_s = count_r;
      end
      case (state_r)
        IDLE:    state_nxt_s = SHIFT;
        SHIFT: begin
          if (count_nxt_s == CNT_W'(DATA_WIDTH)) begin
            state_nxt_s = FULL;
          end else begin
            state_nxt_s = SHIFT;
          end
        end
        FULL:    state_nxt_s = OVER;
        OVER:    state_nxt_s = OVER;
        default: state_nxt_s = IDLE;
      endcase
    end else begin
      state_nxt_s = state_r;
    end

    if (latch_rise_s) begin
      case (state_nxt_s)
        IDLE: begin
          state_nxt_s = IDLE;
        end
        SHIFT: begin
          err_nxt_s   = 1'b1;
          state_nxt_s = IDLE;
          count_nxt_s = '0;
          shreg_nxt_s = '0;
        end
        FULL: begin
          dout_nxt_s  = shreg_nxt_s;
          valid_nxt_s = 1'b1;
          state_nxt_s = IDLE;
          count_nxt_s = '0;
          shreg_nxt_s = '0;
        end
        OVER: begin
          dout_nxt_s  = shreg_nxt_s;
          valid_nxt_s = 1'b1;
          ovr_nxt_s   = 1'b1;
          state_nxt_s = IDLE;
          count_nxt_s = '0;
          shreg_nxt_s = '0;
        end
        default: begin
          state_nxt_s = IDLE;
          count_nxt_s = '0;
          shreg_nxt_s = '0;
        end
      endcase
    end else begin
      dout_nxt_s = dout_nxt_s;
    end
  end

  // Frame state and registered outputs
  always_ff @(posedge ICE_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r     <= IDLE;
      count_r     <= '0;
      shreg_r     <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      count_r     <= count_nxt_s;
      shreg_r     <= shreg_nxt_s;
      data_out    <= dout_nxt_s;
      data_valid  <= valid_nxt_s;
      frame_error <= err_nxt_s;
      overrun     <= ovr_nxt_s;
      busy        <= (state_nxt_s != IDLE);
    end
  end

endmodule

// File: tb/tb_shift_in.sv
// Bench for shift_in: directed scenarios plus random frames, compared against a
// bit-queue model of what a latch should report.
module tb_shift_in;

  logic       clk;
  logic       rst_n;
  logic       sclk;
  logic       sdata;
  logic       slatch;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_error;
  logic       overrun;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int n_valid = 0;
  int n_err   = 0;
  int n_ovr   = 0;

  logic       q[$];
  logic [7:0] exp_data = 8'h00;

  shift_in #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
    .ICE_CLK     (clk),
    .RST_N       (rst_n),
    .SHIFT_CLOCK (sclk),
    .SHIFT_DATA  (sdata),
    .SHIFT_LATCH (slatch),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .frame_error (frame_error),
    .overrun     (overrun),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters, sampled just after each rising edge
  always @(posedge clk) begin
    #1;
    if (data_valid === 1'b1)  n_valid++;
    if (frame_error === 1'b1) n_err++;
    if (overrun === 1'b1)     n_ovr++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input int half);
    sclk  = 1'b0;
    sdata = b;
    tick(half);
    sclk  = 1'b1;
    q.push_back(b);
    tick(half);
  endtask

  task automatic send_bits(input logic [15:0] pat, input int n, input int half);
    for (int i = n - 1; i >= 0; i--) send_bit(pat[i], half);
    sclk = 1'b0;
    tick(half);
  endtask

  // Model: what the latch should report given every bit received since the last one
  task automatic eval_latch(output int ev, output int ee, output int eo);
    int n;
    n  = q.size();
    ev = 0;
    ee = 0;
    eo = 0;
    if (n > 0 && n < 8) begin
      ee = 1;
    end else if (n >= 8) begin
      ev = 1;
      eo = (n > 8) ? 1 : 0;
      for (int i = 0; i < 8; i++) exp_data[7-i] = q[n-8+i];
    end
    q.delete();
  endtask

  task automatic latch_and_check(input string tag, input int half, input bit coincide);
    int v0, e0, o0, ev, ee, eo;
    check({tag, "_busy_pre"}, 32'(busy), 32'(q.size() > 0 || coincide));
    v0 = n_valid; e0 = n_err; o0 = n_ovr;
    if (coincide) begin
      sclk  = 1'b0;
      sdata = 1'b0;
      tick(half);
      sclk  = 1'b1;
      q.push_back(1'b0);
    end
    slatch = 1'b1;
    tick(half);
    sclk   = 1'b0;
    slatch = 1'b0;
    tick(half + 2);
    eval_latch(ev, ee, eo);
    check({tag, "_valid"}, 32'(n_valid - v0), 32'(ev));
    check({tag, "_ferr"},  32'(n_err - e0),   32'(ee));
    check({tag, "_ovr"},   32'(n_ovr - o0),   32'(eo));
    check({tag, "_data"},  32'(data_out),     32'(exp_data));
    check({tag, "_busy_post"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int v0, e0, o0, ev, ee, eo, n, half;
    logic [3:0]  lat;
    logic [15:0] pat;

    rst_n = 1'b0; sclk = 1'b0; sdata = 1'b0; slatch = 1'b0;
    tick(3);
    check("rst_data",  32'(data_out),    32'd0);
    check("rst_valid", 32'(data_valid),  32'd0);
    check("rst_ferr",  32'(frame_error), 32'd0);
    check("rst_ovr",   32'(overrun),     32'd0);
    check("rst_busy",  32'(busy),        32'd0);
    rst_n = 1'b1;
    tick(6);

    // 8'hA5 with latency measured from the latch pin rise
    send_bits(16'h00A5, 8, 8);
    check("a5_busy_pre", 32'(busy), 32'd1);
    v0 = n_valid; e0 = n_err; o0 = n_ovr;
    slatch = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      lat[k] = data_valid;
    end
    check("a5_latency", 32'(lat), 32'b0100);
    tick(8);
    slatch = 1'b0;
    tick(10);
    eval_latch(ev, ee, eo);
    check("a5_valid", 32'(n_valid - v0), 32'(ev));
    check("a5_ferr",  32'(n_err - e0),   32'(ee));
    check("a5_ovr",   32'(n_ovr - o0),   32'(eo));
    check("a5_data",  32'(data_out),     32'(exp_data));
    check("a5_busy_post", 32'(busy), 32'd0);

    send_bits(16'h0016, 5, 6);
    latch_and_check("short", 6, 1'b0);

    send_bits(16'h00F1, 10, 5);
    latch_and_check("long", 5, 1'b0);

    send_bits(16'h001E, 7, 4);
    latch_and_check("coinc", 4, 1'b1);

    // Release with every input idling high
    rst_n = 1'b0; sclk = 1'b1; sdata = 1'b1; slatch = 1'b1;
    tick(3);
    check("hi_rst_data", 32'(data_out), 32'd0);
    q.delete();
    exp_data = 8'h00;
    v0 = n_valid; e0 = n_err; o0 = n_ovr;
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      check("hi_busy", 32'(busy), 32'd0);
    end
    check("hi_pulses", 32'((n_valid - v0) + (n_err - e0) + (n_ovr - o0)), 32'd0);
    sclk = 1'b0; sdata = 1'b0; slatch = 1'b0;
    tick(4);

    // Reset in the middle of a frame, then a clean frame
    for (int i = 0; i < 4; i++) send_bit(1'b1, 4);
    rst_n = 1'b0;
    sclk  = 1'b0;
    tick(3);
    check("mid_rst_busy", 32'(busy), 32'd0);
    q.delete();
    exp_data = 8'h00;
    rst_n = 1'b1;
    tick(6);
    send_bits(16'h0081, 8, 4);
    latch_and_check("after_rst", 4, 1'b0);

    // Random frames, including empty, short, exact and long ones
    for (int f = 0; f < 12; f++) begin
      n    = int'($urandom_range(0, 12));
      half = int'($urandom_range(3, 7));
      pat  = 16'($urandom);
      send_bits(pat, n, half);
      latch_and_check("rand", half, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
